// File: rtl/axis_sample_fifo_if.sv
// axis_sample_fifo_if: sample capture / reader bus of the triplet FIFO.
// rd_ts exists only when SAMPLE_TIMESTAMP_EN is defined.
interface axis_sample_fifo_if #(parameter int DEPTH = 16);
    localparam int AW = $clog2(DEPTH);
    logic [15:0] x_data, y_data, z_data;
    logic capture, rd_req, clr_overflow;
    logic rd_valid, empty, full, overflow;
    logic [15:0] rd_x, rd_y, rd_z;
    logic [AW:0] count;
`ifdef SAMPLE_TIMESTAMP_EN
    logic [31:0] rd_ts;
    modport slave (input x_data, y_data, z_data, capture, rd_req, clr_overflow,
                   output rd_valid, rd_x, rd_y, rd_z, rd_ts, count, empty, full, overflow);
    modport master (output x_data, y_data, z_data, capture, rd_req, clr_overflow,
                    input rd_valid, rd_x, rd_y, rd_z, rd_ts, count, empty, full, overflow);
`else
    modport slave (input x_data, y_data, z_data, capture, rd_req, clr_overflow,
                   output rd_valid, rd_x, rd_y, rd_z, count, empty, full, overflow);
    modport master (output x_data, y_data, z_data, capture, rd_req, clr_overflow,
                    input rd_valid, rd_x, rd_y, rd_z, count, empty, full, overflow);
`endif
endinterface

// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: circular FIFO of x/y/z sample triplets with sticky overflow.
// Define SAMPLE_TIMESTAMP_EN to store a 32-bit cycle stamp with each triplet.
module axis_sample_fifo #(
    parameter int DEPTH = 16
) (
    input logic sys_clk,
    input logic rst_n,
    axis_sample_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int W = 80;
`else
    localparam int W = 48;
`endif
    logic run;
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_nxt;
    logic do_wr, do_rd, drop;
    logic valid_q, empty_q, full_q, ovf_q;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] din, rd_q;
`ifdef SAMPLE_TIMESTAMP_EN
    logic [31:0] ts;
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) ts <= '0;
        else ts <= ts + 32'd1;
    assign din = {ts, bus.x_data, bus.y_data, bus.z_data};
    assign bus.rd_ts = rd_q[79:48];
`else
    assign din = {bus.x_data, bus.y_data, bus.z_data};
`endif
    // run holds off any transfer on the edge that releases reset
    always_comb begin
        do_rd = run && bus.rd_req && !empty_q;
        do_wr = run && bus.capture && (!full_q || do_rd);
        drop = run && bus.capture && full_q && !do_rd;
        cnt_nxt = cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
    always_ff @(posedge sys_clk)
        if (do_wr) mem[wp] <= din;
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            empty_q <= 1'b1;
            full_q <= 1'b0;
            ovf_q <= 1'b0;
            valid_q <= 1'b0;
            rd_q <= '0;
        end else begin
            run <= 1'b1;
            cnt <= cnt_nxt;
            empty_q <= cnt_nxt == '0;
            full_q <= cnt_nxt == (AW+1)'(DEPTH);
            ovf_q <= drop ? 1'b1 : bus.clr_overflow ? 1'b0 : ovf_q;
            valid_q <= do_rd;
            if (do_wr) wp <= wp + AW'(1);
            if (do_rd) begin
                rp <= rp + AW'(1);
                rd_q <= mem[rp];
            end
        end
    end
    assign {bus.rd_x, bus.rd_y, bus.rd_z} = rd_q[47:0];
    assign bus.rd_valid = valid_q;
    assign bus.count = cnt;
    assign bus.empty = empty_q;
    assign bus.full = full_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_axis_sample_fifo.sv
// tb_axis_sample_fifo: directed stimulus with a queue scoreboard checked by a pop monitor.
module tb_axis_sample_fifo;
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int W = 80;
`else
    localparam int W = 48;
`endif
    logic sys_clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] mdl[$];
    logic [W-1:0] exp_q[$];
    logic [31:0] tb_ts;
    logic mdl_ovf = 1'b0;

    axis_sample_fifo_if #(.DEPTH(16)) bus ();
    axis_sample_fifo #(.DEPTH(16)) dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge rst_n)
        if (!rst_n) tb_ts <= 32'd0;
        else tb_ts <= tb_ts + 32'd1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [15:0] x, y, z);
`ifdef SAMPLE_TIMESTAMP_EN
        return {tb_ts, x, y, z};
`else
        return {x, y, z};
`endif
    endfunction

    function automatic logic [W-1:0] rd_word();
`ifdef SAMPLE_TIMESTAMP_EN
        return {bus.rd_ts, bus.rd_x, bus.rd_y, bus.rd_z};
`else
        return {bus.rd_x, bus.rd_y, bus.rd_z};
`endif
    endfunction

    always @(negedge sys_clk)
        if (rst_n && bus.rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_pop", rd_word(), '0);
            else chk("pop_data", rd_word(), exp_q.pop_front());
        end

    task automatic step(input logic cap, input logic [15:0] x, y, z,
                        input logic rd, input logic clr);
        logic rd_ok, cap_ok;
        bus.capture = cap;
        bus.x_data = x;
        bus.y_data = y;
        bus.z_data = z;
        bus.rd_req = rd;
        bus.clr_overflow = clr;
        rd_ok = rd && mdl.size() > 0;
        cap_ok = cap && (mdl.size() < 16 || rd_ok);
        if (rd_ok) exp_q.push_back(mdl.pop_front());
        if (cap_ok) mdl.push_back(pack(x, y, z));
        mdl_ovf = (cap && !cap_ok) ? 1'b1 : clr ? 1'b0 : mdl_ovf;
        @(posedge sys_clk);
        #1;
        bus.capture = 1'b0;
        bus.rd_req = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    task automatic cap1(input logic [15:0] v);
        step(1'b1, v, v ^ 16'h5555, ~v, 1'b0, 1'b0);
    endtask

    task automatic rd1();
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.capture = 1'b0;
        bus.rd_req = 1'b0;
        bus.clr_overflow = 1'b0;
        bus.x_data = '0;
        bus.y_data = '0;
        bus.z_data = '0;
        #22;
        chk("rst_count", W'(bus.count), W'(0));
        chk("rst_empty", W'(bus.empty), W'(1));
        chk("rst_full", W'(bus.full), W'(0));
        chk("rst_ovf", W'(bus.overflow), W'(0));
        chk("rst_valid", W'(bus.rd_valid), W'(0));
        chk("rst_rdx", W'(bus.rd_x), W'(0));
        // capture held through the releasing edge must be ignored
        bus.capture = 1'b1;
        bus.x_data = 16'h9999;
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.capture = 1'b0;
        chk("release_edge_count", W'(bus.count), W'(0));

        step(1'b1, 16'h1234, 16'hABCD, 16'h8000, 1'b0, 1'b0);
        chk("one_count", W'(bus.count), W'(1));
        rd1();
        chk("first_valid", W'(bus.rd_valid), W'(1));
        chk("first_x", W'(bus.rd_x), W'(16'h1234));
        chk("first_y", W'(bus.rd_y), W'(16'hABCD));
        chk("first_z", W'(bus.rd_z), W'(16'h8000));
        chk("first_empty", W'(bus.empty), W'(1));

        rd1();
        chk("empty_rd_valid", W'(bus.rd_valid), W'(0));
        chk("empty_rd_count", W'(bus.count), W'(0));
        chk("empty_rd_x_held", W'(bus.rd_x), W'(16'h1234));

        for (int i = 0; i <= 16; i++) cap1(16'(i));
        chk("fill_full", W'(bus.full), W'(1));
        chk("fill_count", W'(bus.count), W'(16));
        chk("fill_ovf", W'(bus.overflow), W'(1));

        step(1'b1, 16'h00EE, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("clr_vs_drop_ovf", W'(bus.overflow), W'(1));
        step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("clr_ovf", W'(bus.overflow), W'(0));

        step(1'b1, 16'h0077, 16'h0077 ^ 16'h5555, ~16'h0077, 1'b1, 1'b0);
        chk("full_rw_count", W'(bus.count), W'(16));
        chk("full_rw_ovf", W'(bus.overflow), W'(0));
        chk("full_rw_oldest", W'(bus.rd_x), W'(0));
        for (int i = 0; i < 16; i++) rd1();
        chk("drain_last_x", W'(bus.rd_x), W'(16'h0077));
        chk("drain_empty", W'(bus.empty), W'(1));
        chk("drain_ovf", W'(bus.overflow), W'(mdl_ovf));

        step(1'b1, 16'h0042, 16'h0042 ^ 16'h5555, ~16'h0042, 1'b1, 1'b0);
        chk("empty_rw_count", W'(bus.count), W'(1));
        chk("empty_rw_valid", W'(bus.rd_valid), W'(0));
        rd1();
        chk("empty_rw_data", W'(bus.rd_x), W'(16'h0042));

        bus.capture = 1'b1;
        bus.x_data = 16'h0500;
        bus.y_data = 16'h0500 ^ 16'h5555;
        bus.z_data = ~16'h0500;
        for (int i = 0; i < 3; i++) mdl.push_back(pack(16'h0500, 16'h0500 ^ 16'h5555, ~16'h0500)) ;
        repeat (1) @(posedge sys_clk);
        mdl[mdl.size()-2] = pack(16'h0500, 16'h0500 ^ 16'h5555, ~16'h0500);
        mdl[mdl.size()-1] = pack(16'h0500, 16'h0500 ^ 16'h5555, ~16'h0500);
        @(posedge sys_clk);
        mdl[mdl.size()-1] = pack(16'h0500, 16'h0500 ^ 16'h5555, ~16'h0500);
        @(posedge sys_clk);
        #1;
        bus.capture = 1'b0;
        chk("held_capture_count", W'(bus.count), W'(3));
        cap1(16'h0600);
        cap1(16'h0601);
        chk("five_count", W'(bus.count), W'(5));

        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", W'(bus.count), W'(0));
        chk("midrst_empty", W'(bus.empty), W'(1));
        mdl.delete();
        mdl_ovf = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        repeat (9) @(posedge sys_clk);
        #1;
        cap1(16'h0AAA);
        rd1();
        chk("post_rst_x", W'(bus.rd_x), W'(16'h0AAA));
`ifdef SAMPLE_TIMESTAMP_EN
        chk("post_rst_ts", W'(bus.rd_ts), W'(32'd10));
`endif
        @(posedge sys_clk);
        #1;
        chk("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
